// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the instruction loader
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;
  localparam logic [31:0] ADDR_STEP = 32'd4;

  // A load is in progress in any of the three streaming/writing states
  function automatic logic is_load_state(input state_t s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_WRITE);
  endfunction

  // A new start is honoured only once the previous load has settled
  function automatic logic is_rest_state(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte stream in and instruction-memory write port out
interface instr_loader_if;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  // Loader side: consumes the byte stream, drives the memory write port
  modport master (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  // Environment side: byte source and instruction memory
  modport slave (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/instr_loader_byte_assembler.sv
// rtl/instr_loader_byte_assembler.sv - little-endian byte-to-word assembler
module instr_loader_byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic [1:0]  last_idx,
  output logic [31:0] word_next,
  output logic        word_complete
);

  logic [1:0]  byte_idx;
  logic [31:0] shift_reg;

  // New bytes enter at the top so the first byte ends up in bits [7:0]
  assign word_next     = {byte_data, shift_reg[31:8]};
  assign word_complete = byte_valid && (byte_idx == last_idx);

  // Byte index and shift register; clear restarts word alignment for a new load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx  <= 2'd0;
      shift_reg <= 32'd0;
    end else if (clear) begin
      byte_idx  <= 2'd0;
    end else if (byte_valid) begin
      shift_reg <= word_next;
      byte_idx  <= word_complete ? 2'd0 : byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot-time instruction memory writer with core reset hold
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  instr_loader_if.master    bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Wide enough to hold MAX_WORDS itself, not just MAX_WORDS-1
  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   word_index;
  logic [CNT_W-1:0]   word_count;
  logic               accept;
  logic               start_load;
  logic [1:0]         last_idx;
  logic [31:0]        word_next;
  logic               word_complete;
  logic               hdr_bad;
  logic               last_word;

  assign accept     = bus.rx_ready && bus.rx_valid;
  assign start_load = start && is_rest_state(state);
  assign last_idx   = (state == ST_HDR) ? 2'(HDR_BYTES - 1) : 2'(WORD_BYTES - 1);
  assign hdr_bad    = (word_next == 32'd0) || (word_next > 32'(MAX_WORDS));
  assign last_word  = (word_index == word_count - CNT_W'(1));

  instr_loader_byte_assembler u_byte_assembler (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_load),
    .byte_valid    (accept),
    .byte_data     (bus.rx_data),
    .last_idx      (last_idx),
    .word_next     (word_next),
    .word_complete (word_complete)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: header check, per-word write, completion
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) next_state = ST_HDR;
      end
      ST_HDR: begin
        if (word_complete) next_state = hdr_bad ? ST_ERR : ST_DATA;
      end
      ST_DATA: begin
        if (word_complete) next_state = ST_WRITE;
      end
      ST_WRITE: begin
        next_state = last_word ? ST_DONE : ST_DATA;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Word count from the header and index of the next word to write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_index <= '0;
      word_count <= '0;
    end else if (start_load) begin
      word_index <= '0;
    end else if (state == ST_HDR && word_complete && !hdr_bad) begin
      word_count <= word_next[CNT_W-1:0];
    end else if (state == ST_WRITE) begin
      word_index <= word_index + CNT_W'(1);
    end
  end

  // Registered outputs decoded from the upcoming state; address/data captured on entry to WRITE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rx_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= BASE_ADDR;
      bus.wr_data  <= 32'd0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      bus.rx_ready <= (next_state == ST_HDR) || (next_state == ST_DATA);
      bus.wr_en    <= (next_state == ST_WRITE);
      cpu_reset    <= (next_state != ST_DONE);
      busy         <= is_load_state(next_state);
      done         <= (next_state == ST_DONE);
      error        <= (next_state == ST_ERR);
      if (state == ST_DATA && word_complete) begin
        bus.wr_addr <= BASE_ADDR + 32'(word_index) * ADDR_STEP;
        bus.wr_data <= word_next;
      end
    end
  end

endmodule
